nvram_upload_server: RTL and testbench
======================================

# nvram_upload_server

Responder for the HPS upload direction of the ioctl channel: the counterpart to the ROM/DIP download path, serving core memory bytes to the HPS for high-score/NVRAM saving. It sits in `emu` beside `hps_io` on `clk_sys`. On each HPS byte request it:
- pauses the game CPU;
- reads one byte through a spare RAM port;
- returns the byte on `ioctl_din`, stalling the HPS with `ioctl_wait` while the fetch is in progress.

## Interface
Parameters:
- `ADDR_W`, 10: NVRAM region is 2^ADDR_W bytes (SIZE).
- `UPLOAD_INDEX`, 4: ioctl_index value this block answers.

Ports:
- `clk_sys`  in  1  system clock (9.987 MHz).
- `RESET_N`  in  1  asynchronous, active-low reset.
- `ioctl_upload`  in  1  HPS upload session active.
- `ioctl_index`  in  8  session index.
- `ioctl_rd`  in  1  one-cycle byte request.
- `ioctl_addr`  in  25  requested byte address.
- `ioctl_din`  out  8  returned byte.
- `ioctl_wait`  out  1  HPS must stall while high.
- `pause_req`  out  1  request CPU halt.
- `pause_ack`  in  1  CPU halted.
- `mem_addr`  out  ADDR_W  RAM read address.
- `mem_rd`  out  1  RAM read strobe.
- `mem_q`  in  8  RAM data; valid exactly one cycle after `mem_rd`.
- `busy`  out  1  session owned by this block (state ≠ IDLE).

## Operation
- Session start: `active` = `ioctl_upload & (ioctl_index == UPLOAD_INDEX)`. Other indices are ignored entirely and all outputs stay at reset values.
- FSM states: IDLE, PAUSE, READY, FETCH, CAPTURE.
- IDLE → PAUSE on `active`.
- PAUSE:
  - `pause_req` = 1 and `ioctl_wait` = 1.
  - → READY on the first cycle `pause_ack` = 1 is sampled.
  - `pause_ack` is sampled only in PAUSE.
- READY:
  - `pause_req` stays 1 and `ioctl_wait` = 0.
  - On `ioctl_rd`, latch `ioctl_addr`.
  - If addr < SIZE: drive `mem_addr` = addr[ADDR_W-1:0], pulse `mem_rd`, → FETCH.
  - Otherwise: `ioctl_din` ← 8'hFF at the next edge, no memory access, stay in READY.
- FETCH → CAPTURE unconditionally (RAM latency cycle).
- CAPTURE: `ioctl_din` ← `mem_q`, → READY.
- `ioctl_wait` = `ioctl_rd` (combinational, in READY) | (state ∈ {PAUSE, FETCH, CAPTURE}).
- `ioctl_rd` in any state other than READY is ignored (the protocol forbids it while wait is high).
- Session end: `active` falling in any state → IDLE at the next edge.
  - `pause_req` drops on that edge.
  - An in-flight FETCH/CAPTURE is abandoned and `ioctl_din` keeps its last value.
- `ioctl_addr` bits above ADDR_W, and above SIZE (or SIZE+1 with checksum), return 8'hFF.

## Timing
- Reset (async, `RESET_N` low): state IDLE; `ioctl_din` = 0; `ioctl_wait`, `pause_req`, `mem_rd`, `busy` = 0; `mem_addr` = 0.
- In-range read: `ioctl_rd` at cycle T.
  - `mem_rd` is registered high during T+1.
  - `ioctl_din` is valid and `ioctl_wait` low from T+3.
  - Wait is high for cycles T..T+2.
- Out-of-range read: data valid at T+1, wait high only during T.
- Pause entry: `pause_req` rises the cycle after `active` rises. Wait stays high until one cycle after `pause_ack` is sampled.
- Back-to-back requests are accepted on the first READY cycle after CAPTURE.

## Configuration
- `NVRAM_CHECKSUM_EN` defined:
  - An 8-bit running sum accumulates every in-range byte captured; it is cleared on session start.
  - A read at addr == SIZE returns the two's complement of the sum, so all delivered bytes sum to 8'h00. Latency is the same as out-of-range (T+1).
- Not defined: addr == SIZE returns 8'hFF and there is no sum register.

## Structure
- Shared package `ioctl_pkg`:
  - State enum `upl_state_t`.
  - Index constants `IDX_ROM` = 0, `IDX_NVRAM` = 4, `IDX_DIP` = 254.
  - `FILL_BYTE` = 8'hFF.
- No sub-module. The checksum is a single accumulator inline, under the macro.

## Test plan
- Reset mid-READY with `RESET_N` pulsed low → all outputs 0 immediately; FSM IDLE; `pause_req` 0 with no clock edge needed.
- Upload index 4 with `pause_ack` delayed 5 cycles → `ioctl_wait` high 6 cycles; `pause_req` 1 throughout; no `mem_rd` before ack.
- RAM preloaded addr 0x123 = 8'hA5; `ioctl_rd` with addr 0x123 → `mem_addr` = 0x123 with one `mem_rd` pulse; `ioctl_din` = 8'hA5 at T+3; wait high exactly 3 cycles.
- Read addr 0x7FF (ADDR_W = 10, no macro) → `ioctl_din` = 8'hFF at T+1; no `mem_rd`.
- With `NVRAM_CHECKSUM_EN`: bytes 0x10, 0x20, 0x30 then read at addr 0x400 → returns 8'hA0.
- `ioctl_upload` dropped during FETCH → IDLE next edge; `pause_req` 0; `ioctl_din` unchanged. Upload with index 0 → no response, `busy` 0.

Source files
------------

// File: rtl/ioctl_pkg.sv
// Shared ioctl definitions: upload FSM states, session index constants and fill byte.
package ioctl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PAUSE,
        READY,
        FETCH,
        CAPTURE
    } upl_state_t;

    localparam logic [7:0] IDX_ROM   = 8'd0;
    localparam logic [7:0] IDX_NVRAM = 8'd4;
    localparam logic [7:0] IDX_DIP   = 8'd254;
    localparam logic [7:0] FILL_BYTE = 8'hFF;

endpackage

// File: rtl/nvram_upload_server.sv
// Serves NVRAM bytes to the HPS over the ioctl upload channel, pausing the CPU for the session.
// Optional NVRAM_CHECKSUM_EN: a read at addr == SIZE returns the negated byte sum of the session.
module nvram_upload_server
    import ioctl_pkg::*;
#(
    parameter int         ADDR_W       = 10,
    parameter logic [7:0] UPLOAD_INDEX = IDX_NVRAM
) (
    input  logic              clk_sys,
    input  logic              RESET_N,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              pause_req,
    input  logic              pause_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_q,
    output logic              busy
);

    localparam logic [24:0] SIZE = 25'd1 << ADDR_W;

    upl_state_t        state_reg, state_next;
    logic [7:0]        din_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic              mem_rd_reg;
    logic              active;
    logic              rd_accept;
    logic              in_range;
    logic [7:0]        fill_value;

    assign active    = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
    assign rd_accept = (state_reg == READY) && active && ioctl_rd;
    assign in_range  = (ioctl_addr < SIZE);

`ifdef NVRAM_CHECKSUM_EN
    logic [7:0] sum_reg;

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            sum_reg <= 8'd0;
        end else if (state_reg == IDLE && active) begin
            sum_reg <= 8'd0;
        end else if (state_reg == CAPTURE && active) begin
            sum_reg <= sum_reg + mem_q;
        end
    end

    // Returning the negated sum makes every byte delivered this session add up to zero.
    assign fill_value = (ioctl_addr == SIZE) ? (8'd0 - sum_reg) : FILL_BYTE;
`else
    assign fill_value = FILL_BYTE;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (active) state_next = PAUSE;
            PAUSE:   if (pause_ack) state_next = READY;
            READY:   if (rd_accept && in_range) state_next = FETCH;
            FETCH:   state_next = CAPTURE;
            CAPTURE: state_next = READY;
            default: state_next = IDLE;
        endcase
        // Session end abandons whatever is in flight.
        if (!active) state_next = IDLE;
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg    <= IDLE;
            din_reg      <= 8'd0;
            mem_addr_reg <= '0;
            mem_rd_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            mem_rd_reg <= rd_accept && in_range;
            if (rd_accept && in_range) begin
                mem_addr_reg <= ioctl_addr[ADDR_W-1:0];
            end
            if (rd_accept && !in_range) begin
                din_reg <= fill_value;
            end else if (state_reg == CAPTURE && active) begin
                din_reg <= mem_q;
            end
        end
    end

    assign ioctl_din  = din_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_rd     = mem_rd_reg;
    assign pause_req  = (state_reg != IDLE);
    assign busy       = (state_reg != IDLE);
    assign ioctl_wait = ((state_reg == READY) && ioctl_rd) ||
                        (state_reg == PAUSE) || (state_reg == FETCH) || (state_reg == CAPTURE);

endmodule

// File: tb/tb_nvram_upload_server.sv
// Self-checking bench for nvram_upload_server: directed steps plus randomized reads vs. a byte-level model.
module tb_nvram_upload_server;

    localparam int SIZE = 1024;

    logic        clk_sys = 1'b0;
    logic        RESET_N = 1'b0;
    logic        ioctl_upload = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_rd = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        pause_req;
    logic        pause_ack = 1'b0;
    logic [9:0]  mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_q = 8'd0;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] ram [0:SIZE-1];
    logic [7:0] sum_model;

    nvram_upload_server #(.ADDR_W(10), .UPLOAD_INDEX(8'd4)) dut (
        .clk_sys      (clk_sys),
        .RESET_N      (RESET_N),
        .ioctl_upload (ioctl_upload),
        .ioctl_index  (ioctl_index),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .ioctl_wait   (ioctl_wait),
        .pause_req    (pause_req),
        .pause_ack    (pause_ack),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_q        (mem_q),
        .busy         (busy)
    );

    always #5 clk_sys = ~clk_sys;

    // RAM with one-cycle read latency
    always @(posedge clk_sys) begin
        if (mem_rd) mem_q <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_session(input int ack_delay);
        int wcnt;
        int bad;
        wcnt = 0;
        bad  = 0;
        @(posedge clk_sys); #1;
        pause_ack    = 1'b0;
        ioctl_upload = 1'b1;
        ioctl_index  = 8'd4;
        sum_model    = 8'd0;
        @(negedge clk_sys);
        check("preq_before_edge", {31'd0, pause_req}, 32'd0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_sys); #1;
            if (i == ack_delay) pause_ack = 1'b1;
            @(negedge clk_sys);
            if (!ioctl_wait) break;
            wcnt++;
            if (!pause_req || mem_rd) bad++;
        end
        check("pause_wait_cycles", wcnt, ack_delay + 1);
        check("pause_preq_no_mem", bad, 0);
        $display("session start: ack_delay=%0d wait_cycles=%0d", ack_delay, wcnt);
    endtask

    task automatic end_session();
        @(posedge clk_sys); #1;
        ioctl_upload = 1'b0;
        @(posedge clk_sys); #1;
        pause_ack = 1'b0;
        @(negedge clk_sys);
        check("end_idle", {29'd0, busy, pause_req, ioctl_wait}, 32'd0);
        $display("session end: busy=%0b pause_req=%0b", busy, pause_req);
    endtask

    task automatic do_read(input logic [24:0] a);
        int         wcnt;
        int         rdcnt;
        int         exp_w;
        int         exp_rd;
        logic [7:0] exp;
        logic [9:0] seen_addr;
        seen_addr = '0;
        if (a < SIZE) begin
            exp    = ram[a[9:0]];
            exp_w  = 3;
            exp_rd = 1;
        end else begin
            exp    = 8'hFF;
            exp_w  = 1;
            exp_rd = 0;
`ifdef NVRAM_CHECKSUM_EN
            if (a == SIZE) exp = 8'd0 - sum_model;
`endif
        end
        @(posedge clk_sys); #1;
        ioctl_rd   = 1'b1;
        ioctl_addr = a;
        @(negedge clk_sys);
        wcnt  = ioctl_wait ? 1 : 0;
        rdcnt = mem_rd ? 1 : 0;
        @(posedge clk_sys); #1;
        ioctl_rd = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_sys);
            if (mem_rd) begin
                rdcnt++;
                seen_addr = mem_addr;
            end
            if (!ioctl_wait) break;
            wcnt++;
        end
        check("read_data", ioctl_din, exp);
        check("read_wait_cycles", wcnt, exp_w);
        check("read_mem_rd_count", rdcnt, exp_rd);
        if (exp_rd == 1) begin
            check("read_mem_addr", seen_addr, a[9:0]);
            sum_model = sum_model + exp;
        end
        $display("read addr=%07h data=%02h exp=%02h wait=%0d mem_rd=%0d", a, ioctl_din, exp, wcnt, rdcnt);
    endtask

    initial begin
        logic [24:0] a;
        int          sel;
        logic [7:0]  prev;

        for (int i = 0; i < SIZE; i++) ram[i] = 8'($urandom);
        ram[10'h123] = 8'hA5;
        ram[10'h005] = 8'h3C;
        sum_model = 8'd0;

        // Reset state
        #12;
        check("reset_outputs", {ioctl_din, 10'd0, mem_addr, mem_rd, busy, pause_req, ioctl_wait},
              32'd0);
        @(posedge clk_sys); #1;
        RESET_N = 1'b1;

        // Directed: delayed ack, in-range and out-of-range reads
        start_session(5);
        do_read(25'h123);
        do_read(25'h7FF);
        do_read(25'h1FFFFFF);
        do_read(25'h3FF);

        // Reset pulsed mid-READY: outputs clear with no clock edge
        @(posedge clk_sys); #2;
        RESET_N = 1'b0;
        #1;
        check("async_reset", {ioctl_din, 10'd0, mem_addr, mem_rd, busy, pause_req, ioctl_wait},
              32'd0);
        $display("async reset: busy=%0b din=%02h", busy, ioctl_din);
        ioctl_upload = 1'b0;
        pause_ack    = 1'b0;
        @(posedge clk_sys); #1;
        RESET_N = 1'b1;

        // Randomized sessions
        for (int s = 0; s < 3; s++) begin
            start_session($urandom_range(0, 6));
            for (int r = 0; r < 8; r++) begin
                sel = $urandom_range(0, 9);
                if (sel < 6)       a = 25'($urandom_range(0, SIZE - 1));
                else if (sel < 8)  a = 25'($urandom_range(SIZE, 32'h1FFFFFF));
                else if (sel == 8) a = 25'(SIZE);
                else               a = 25'(SIZE - 1);
                do_read(a);
            end
            end_session();
        end

`ifdef NVRAM_CHECKSUM_EN
        start_session(0);
        ram[0] = 8'h10;
        ram[1] = 8'h20;
        ram[2] = 8'h30;
        do_read(25'h0);
        do_read(25'h1);
        do_read(25'h2);
        do_read(25'h400);
        check("checksum_a0", ioctl_din, 32'hA0);
        end_session();
`endif

        // Session dropped during FETCH
        start_session(1);
        do_read(25'h7FF);
        prev = ioctl_din;
        @(posedge clk_sys); #1;
        ioctl_rd   = 1'b1;
        ioctl_addr = 25'h005;
        @(posedge clk_sys); #1;
        ioctl_rd     = 1'b0;
        ioctl_upload = 1'b0;
        @(negedge clk_sys);
        check("abort_in_fetch", {31'd0, busy}, 32'd1);
        @(negedge clk_sys);
        check("abort_idle", {30'd0, busy, pause_req}, 32'd0);
        check("abort_din_kept", ioctl_din, prev);
        repeat (3) @(negedge clk_sys);
        check("abort_din_still", ioctl_din, prev);
        $display("abort: busy=%0b pause_req=%0b din=%02h", busy, pause_req, ioctl_din);
        pause_ack = 1'b0;

        // Foreign index ignored
        @(posedge clk_sys); #1;
        ioctl_upload = 1'b1;
        ioctl_index  = 8'd0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk_sys); #1;
            ioctl_rd   = ~ioctl_rd;
            ioctl_addr = 25'h010;
            @(negedge clk_sys);
            check("foreign_idx_quiet", {28'd0, busy, pause_req, ioctl_wait, mem_rd}, 32'd0);
            check("foreign_idx_din", ioctl_din, prev);
        end
        $display("foreign index: busy=%0b din=%02h", busy, ioctl_din);
        ioctl_rd     = 1'b0;
        ioctl_upload = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
